// File: rtl/wb_timer_if.sv
// Wishbone B4 classic bus bundle for the wb_timer responder.
// Signal names are taken from the responder's point of view (_i into the timer, _o out of it).
interface wb_timer_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o, err_o, rty_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o, err_o, rty_o
    );
endinterface

// File: rtl/wb_timer.sv
// wb_timer: Wishbone B4 classic memory-mapped 32-bit timer with prescaler and
// compare-match interrupt. Five word registers live in a 32-byte window at BASE_ADDR.
// Optional feature macro: WB_TIMER_BUS_ERR_EN -- when defined, bad offsets and
// misaligned addresses terminate with err_o; otherwise they ack (reads 0, writes dropped).
module wb_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_timer_if.slave   bus,
    output logic        irq_o
);
    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_PRESC  = 3'd1;
    localparam logic [2:0] IDX_COUNT  = 3'd2;
    localparam logic [2:0] IDX_CMP    = 3'd3;
    localparam logic [2:0] IDX_STATUS = 3'd4;

    // Architectural state
    logic [2:0]                ctrl_q, ctrl_d;          // [0]EN [1]AUTO_RELOAD [2]IRQ_EN
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;            // free-running prescaler counter
    logic [31:0]               count_q, count_d;
    logic [31:0]               cmp_q, cmp_d;
    logic                      match_q, match_d;
    logic                      ovf_q, ovf_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic [31:0]               dat_q, dat_d;

    // Bus decode
    logic [2:0]  idx;
    logic        hit, req, off_ok, wr_en, rd_en;
    logic [31:0] wmask, rdata, wr_val, w1c;

    assign idx    = bus.adr_i[4:2];
    assign hit    = (bus.adr_i[31:5] == BASE_ADDR[31:5]);
    assign req    = bus.cyc_i & bus.stb_i & ~ack_q & ~err_q & hit;
    assign off_ok = (bus.adr_i[1:0] == 2'b00) & (idx <= IDX_STATUS);
    // sel_i == 0 is a legal write that changes nothing, so it is folded in here
    assign wr_en  = req & bus.we_i & off_ok & (|bus.sel_i);
    assign rd_en  = req & ~bus.we_i & off_ok;

    // Expand byte-lane selects into a bit mask
    for (genvar n = 0; n < 4; n++) begin : g_lane
        assign wmask[8*n +: 8] = {8{bus.sel_i[n]}};
    end

    // Current value of the addressed register; also the base for partial writes
    always_comb begin
        rdata = 32'd0;
        case (idx)
            IDX_CTRL:   rdata = {29'd0, ctrl_q};
            IDX_PRESC:  rdata = 32'(presc_q);
            IDX_COUNT:  rdata = count_q;
            IDX_CMP:    rdata = cmp_q;
            IDX_STATUS: rdata = {30'd0, ovf_q, match_q};
            default:    rdata = 32'd0;
        endcase
    end

    assign wr_val = (rdata & ~wmask) | (bus.dat_i & wmask);
    assign w1c    = bus.dat_i & wmask;

    // Tick and counter events, all derived from registered state
    logic tick, set_match, set_ovf;
    assign tick      = ctrl_q[0] & (psc_q == presc_q);
    assign set_match = tick & (count_q == cmp_q);
    assign set_ovf   = tick & (count_q == 32'hFFFF_FFFF);

    // Next-state: timer progression first, then bus writes override where they collide
    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        psc_d   = psc_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        match_d = match_q | set_match;
        ovf_d   = ovf_q | set_ovf;

        if (ctrl_q[0]) psc_d = tick ? '0 : psc_q + 1'b1;

        if (tick) count_d = (set_match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;

        if (wr_en) begin
            case (idx)
                IDX_CTRL:  ctrl_d = wr_val[2:0];
                IDX_PRESC: begin
                    presc_d = wr_val[PRESCALE_WIDTH-1:0];
                    psc_d   = '0;
                end
                IDX_COUNT: count_d = wr_val;
                IDX_CMP:   cmp_d   = wr_val;
                // hardware set wins over the clear so no event is lost
                IDX_STATUS: begin
                    match_d = (match_q & ~w1c[0]) | set_match;
                    ovf_d   = (ovf_q & ~w1c[1]) | set_ovf;
                end
                default: ;
            endcase
        end

`ifdef WB_TIMER_BUS_ERR_EN
        ack_d = req & off_ok;
        err_d = req & ~off_ok;
`else
        ack_d = req;
        err_d = 1'b0;
`endif
        dat_d = rd_en ? rdata : 32'd0;
    end

    // State registers with synchronous reset; a write on a reset cycle is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            psc_q   <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            psc_q   <= psc_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    assign bus.ack_o = ack_q;
    assign bus.err_o = err_q;
    assign bus.rty_o = 1'b0;
    assign bus.dat_o = dat_q;
    assign irq_o     = ctrl_q[2] & match_q;
endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed scenarios plus randomized bus traffic,
// compared cycle by cycle against a behavioural model of the register map.
module tb_wb_timer;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          PW   = 16;
`ifdef WB_TIMER_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    wb_timer_if bus();

    wb_timer #(.BASE_ADDR(BASE), .PRESCALE_WIDTH(PW)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [2:0]  m_ctrl;
    logic [31:0] m_pre, m_psc, m_cnt, m_cmp, m_dat;
    logic        m_match, m_ovf, m_ack, m_err;

    function automatic logic [31:0] m_reg(input logic [31:0] off);
        case (off)
            0:  return {29'd0, m_ctrl};
            4:  return m_pre;
            8:  return m_cnt;
            12: return m_cmp;
            16: return {30'd0, m_ovf, m_match};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] off, mask, nv, nc;
        bit req, ok, wr, tick, smatch, sovf, nm, no;
        if (rst) begin
            m_ctrl <= 0; m_pre <= 0; m_psc <= 0; m_cnt <= 0; m_cmp <= 0;
            m_match <= 0; m_ovf <= 0; m_ack <= 0; m_err <= 0; m_dat <= 0;
        end else begin
            off  = bus.adr_i - BASE;
            req  = bus.cyc_i && bus.stb_i && !m_ack && !m_err && (off < 32);
            ok   = (off % 4 == 0) && (off <= 16);
            for (int i = 0; i < 4; i++) mask[8*i +: 8] = bus.sel_i[i] ? 8'hFF : 8'h00;
            wr   = req && bus.we_i && ok && (bus.sel_i != 0);
            nv   = (m_reg(off) & ~mask) | (bus.dat_i & mask);
            tick = m_ctrl[0] && (m_psc == m_pre);
            smatch = tick && (m_cnt == m_cmp);
            sovf   = tick && (m_cnt == 32'hFFFF_FFFF);
            nc = m_cnt;
            if (tick) nc = (smatch && m_ctrl[1]) ? 0 : m_cnt + 1;
            nm = m_match || smatch;
            no = m_ovf || sovf;
            if (m_ctrl[0]) m_psc <= tick ? 0 : m_psc + 1;
            if (wr) begin
                if (off == 0)  m_ctrl <= nv[2:0];
                if (off == 4) begin m_pre <= nv & ((1 << PW) - 1); m_psc <= 0; end
                if (off == 8)  nc = nv;
                if (off == 12) m_cmp <= nv;
                if (off == 16) begin
                    nm = (m_match && !(bus.dat_i[0] && bus.sel_i[0])) || smatch;
                    no = (m_ovf && !(bus.dat_i[1] && bus.sel_i[0])) || sovf;
                end
            end
            m_cnt   <= nc;
            m_match <= nm;
            m_ovf   <= no;
            m_ack   <= req && (ok || !ERR_EN);
            m_err   <= req && !ok && ERR_EN;
            m_dat   <= (req && !bus.we_i && ok) ? m_reg(off) : 0;
        end
    end

    // Cycle-by-cycle compare of every output against the model
    always @(negedge clk) begin
        if (mon_on) begin
            chk("ack", {31'd0, bus.ack_o}, {31'd0, m_ack});
            chk("err", {31'd0, bus.err_o}, {31'd0, m_err});
            chk("rty", {31'd0, bus.rty_o}, 32'd0);
            chk("dat", bus.dat_o, m_dat);
            chk("irq", {31'd0, irq}, {31'd0, m_ctrl[2] & m_match});
        end
    end

    // ---------------- bus helpers (called just after a posedge) ----------------
    task automatic access(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] d, output logic [31:0] rd,
                          output bit ack, output bit err);
        bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = we;
        bus.adr_i = adr; bus.sel_i = sel; bus.dat_i = d;
        @(posedge clk);
        @(negedge clk);
        rd = bus.dat_o; ack = bus.ack_o; err = bus.err_o;
        @(posedge clk); #1;
        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
    endtask

    task automatic wr32(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] rd; bit a, e;
        access(1'b1, BASE + off, 4'hF, d, rd, a, e);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] rd; bit a, e;
        access(1'b0, BASE + off, 4'hF, 32'h0, rd, a, e);
        chk(tag, rd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd, d, off;
        bit a, e, seen;
        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
        bus.adr_i = 0; bus.sel_i = 0; bus.dat_i = 0;
        @(posedge clk); mon_on = 1;
        idle(3);
        rst = 0;

        // 1: reset values, single-cycle ack latency
        for (int i = 0; i <= 16; i += 4) begin
            access(1'b0, BASE + i, 4'hF, 32'h0, rd, a, e);
            chk("rst_read", rd, 32'd0);
            chk("rst_ack", {31'd0, a}, 32'd1);
        end
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // 2: prescaled count to compare match, then W1C
        wr32(4, 3); wr32(12, 5); wr32(0, 7);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = irq; end
        chk("irq_rise", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        rd_chk("match_status", 16, 32'd1);
        wr32(16, 1);
        chk("irq_clr", {31'd0, irq}, 32'd0);

        // 3: wrap sets OVF but not MATCH with COMPARE=0
        wr32(0, 0); wr32(4, 0); wr32(12, 0); wr32(8, 32'hFFFF_FFFE); wr32(16, 3);
        wr32(0, 1); wr32(0, 0);
        rd_chk("wrap_count", 8, 32'd0);
        rd_chk("wrap_status", 16, 32'd2);

        // 4: byte-lane write
        wr32(8, 32'h1234_5678);
        access(1'b1, BASE + 8, 4'b0010, 32'hAAAA_BBCC, rd, a, e);
        rd_chk("lane_write", 8, 32'h1234_BB78);

        // 5: set beats W1C; COUNT write beats tick
        wr32(8, 0); wr32(12, 1); wr32(16, 3);
        wr32(0, 1); wr32(16, 1);
        rd_chk("set_beats_clr", 16, 32'd1);
        wr32(8, 32'h100); wr32(0, 0);
        rd_chk("wr_beats_tick", 8, 32'h102);

        // 6: invalid offset, misaligned, out of window
        access(1'b0, BASE + 32'h14, 4'hF, 32'h0, rd, a, e);
        chk("bad_off_ack", {31'd0, a}, {31'd0, !ERR_EN});
        chk("bad_off_err", {31'd0, e}, {31'd0, ERR_EN});
        chk("bad_off_dat", rd, 32'd0);
        access(1'b0, BASE + 32'h2, 4'hF, 32'h0, rd, a, e);
        chk("misal_ack", {31'd0, a}, {31'd0, !ERR_EN});
        chk("misal_err", {31'd0, e}, {31'd0, ERR_EN});
        access(1'b1, BASE + 32'h1C, 4'hF, 32'hFFFF_FFFF, rd, a, e);
        rd_chk("bad_wr_noeff", 0, 32'd0);
        bus.cyc_i = 1; bus.stb_i = 1; bus.adr_i = BASE + 32'h40;
        seen = 0;
        repeat (8) begin @(negedge clk); seen = seen | bus.ack_o | bus.err_o; end
        chk("oow_noterm", {31'd0, seen}, 32'd0);
        @(posedge clk); #1; bus.cyc_i = 0; bus.stb_i = 0;

        // reset on a write request cycle: no ack, write dropped
        wr32(12, 32'h55);
        bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = BASE + 12;
        bus.sel_i = 4'hF; bus.dat_i = 32'hDEAD; rst = 1;
        @(posedge clk); #1;
        rst = 0; bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
        @(negedge clk);
        chk("rst_squash_ack", {31'd0, bus.ack_o}, 32'd0);
        @(posedge clk); #1;
        rd_chk("rst_discard", 12, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int kind;
            kind = $urandom_range(0, 19);
            if (kind < 17) begin
                off = 4 * $urandom_range(0, 4);
                case (off)
                    0:  d = $urandom_range(0, 3) != 0 ? ($urandom & 7) | 1 : $urandom & 7;
                    4:  d = $urandom_range(0, 3);
                    8:  d = $urandom_range(0, 1) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                 : $urandom_range(0, 20);
                    12: d = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFF : $urandom_range(0, 20);
                    default: d = $urandom;
                endcase
                access($urandom_range(0, 1) == 1, BASE + off,
                       $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF, d, rd, a, e);
            end else if (kind < 19) begin
                access($urandom_range(0, 1) == 1, BASE + 32'h14 + $urandom_range(0, 11),
                       4'hF, $urandom, rd, a, e);
            end else begin
                bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1;
                bus.adr_i = BASE + 32'h20 + 4 * $urandom_range(0, 255);
                bus.dat_i = $urandom; bus.sel_i = 4'hF;
                idle($urandom_range(1, 4));
                bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
            end
            idle($urandom_range(0, 3));
        end

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
